word_checker: RTL and testbench

Avalon-ST sink that receives messages from a word generator (or any zero-payload traffic source) and checks them for framing, length and payload correctness. It counts received words and completed messages and exposes sticky error flags for onboard debug readout. It sits at the far end of a debug loopback, the consuming counterpart of the word generator.

---
 rtl/word_check_pkg.sv | 17 +
 rtl/avalon_st_if.sv | 15 +
 rtl/word_checker.sv | 161 ++++++++++++++++
 tb/tb_word_checker.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/word_check_pkg.sv
// Shared types for the word checker: FSM state and sticky error flag group.
package word_check_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      IN_MSG = 1'b1
   } state_e;

   // Sticky error bits, grouped for register-map readout
   typedef struct packed {
      logic sop;   // beat without sop while idle
      logic eop;   // sop while a message is open
      logic len;   // completed length differs from expected
      logic data;  // nonzero data or empty on an accepted beat
   } err_flags_t;

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST stream interface with sop/eop/empty framing.
interface avalon_st_if #(
   parameter int unsigned DATA_WIDTH  = 128,
   parameter int unsigned EMPTY_WIDTH = (DATA_WIDTH / 8 > 1) ? $clog2(DATA_WIDTH / 8) : 1
);
   logic [DATA_WIDTH-1:0]  data;
   logic                   valid;
   logic                   ready;
   logic                   sop;
   logic                   eop;
   logic [EMPTY_WIDTH-1:0] empty;

   modport master (output data, output valid, input ready, output sop, output eop, output empty);
   modport slave  (input data, input valid, output ready, input sop, input eop, input empty);
endinterface

// File: rtl/word_checker.sv
// Avalon-ST sink that checks framing, length and zero payload of incoming messages.
module word_checker
   import word_check_pkg::*;
#(
   parameter int unsigned DATA_WIDTH        = 128,
   parameter int unsigned WORD_COUNTER_SIZE = 8,
   parameter int unsigned MSG_COUNTER_SIZE  = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   avalon_st_if.slave                   msg_in,
   input  logic [WORD_COUNTER_SIZE-1:0] msg_word_cnt,
   input  logic                         sink_en,
   input  logic                         err_clear,
   output logic                         msg_done,
   output logic                         msg_ok,
   output logic [WORD_COUNTER_SIZE-1:0] msg_len,
   output logic [MSG_COUNTER_SIZE-1:0]  msg_count,
   output logic                         err_sop,
   output logic                         err_eop,
   output logic                         err_len,
   output logic                         err_data
);

   localparam int unsigned WCW = WORD_COUNTER_SIZE;
   localparam int unsigned MCW = MSG_COUNTER_SIZE;

   state_e         state_q, state_d;
   logic [WCW-1:0] cnt_q, cnt_d;
   logic [WCW-1:0] exp_q, exp_d;
   logic           sat_q, sat_d;       // counter overflowed in the open message
   logic           bad_q, bad_d;       // data error seen in the open message
   err_flags_t     err_q, err_d;
   logic           done_q, done_d;
   logic           ok_q, ok_d;
   logic [WCW-1:0] len_q, len_d;
   logic [MCW-1:0] count_q, count_d;

   logic [DATA_WIDTH-1:0] beat_data;
   logic                  accepted;
   logic                  beat_derr;

   // Values as updated by this beat, used both for state and completion
   logic [WCW-1:0] cnt_n, exp_n;
   logic           sat_n, bad_n, fin, len_err;

   // Ready is a pure pass-through of the enable for backpressure testing
   assign msg_in.ready = sink_en;
   assign beat_data    = msg_in.data;
   assign accepted     = msg_in.valid & sink_en;
   assign beat_derr    = (|beat_data) | (|msg_in.empty);

   // Next-state: framing FSM, word counting, completion and sticky errors
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      exp_d   = exp_q;
      sat_d   = sat_q;
      bad_d   = bad_q;
      err_d   = err_q;
      done_d  = 1'b0;
      ok_d    = ok_q;
      len_d   = len_q;
      count_d = count_q;
      cnt_n   = cnt_q;
      exp_n   = exp_q;
      sat_n   = sat_q;
      bad_n   = bad_q;
      fin     = 1'b0;
      len_err = 1'b0;

      // Clear first so an error or completion in the same cycle wins
      if (err_clear) begin
         err_d   = '0;
         count_d = '0;
      end

      if (accepted) begin
         if (beat_derr) begin
            err_d.data = 1'b1;
         end
         if (msg_in.sop) begin
            // A sop always starts a fresh message; an open one is abandoned
            if (state_q == IN_MSG) begin
               err_d.eop = 1'b1;
            end
            exp_n   = msg_word_cnt;
            cnt_n   = WCW'(1);
            sat_n   = 1'b0;
            bad_n   = beat_derr;
            fin     = msg_in.eop;
            state_d = msg_in.eop ? IDLE : IN_MSG;
         end else if (state_q == IN_MSG) begin
            if (&cnt_q) begin
               sat_n = 1'b1;
            end else begin
               cnt_n = cnt_q + WCW'(1);
            end
            bad_n = bad_q | beat_derr;
            fin   = msg_in.eop;
            if (msg_in.eop) begin
               state_d = IDLE;
            end
         end else begin
            err_d.sop = 1'b1;
         end
         cnt_d = cnt_n;
         exp_d = exp_n;
         sat_d = sat_n;
         bad_d = bad_n;
      end

      if (fin) begin
         len_err = (cnt_n != exp_n) | sat_n;
         done_d  = 1'b1;
         len_d   = cnt_n;
         count_d = count_d + MCW'(1);
         ok_d    = ~len_err & ~bad_n;
         if (len_err) begin
            err_d.len = 1'b1;
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         exp_q   <= '0;
         sat_q   <= 1'b0;
         bad_q   <= 1'b0;
         err_q   <= '0;
         done_q  <= 1'b0;
         ok_q    <= 1'b0;
         len_q   <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         exp_q   <= exp_d;
         sat_q   <= sat_d;
         bad_q   <= bad_d;
         err_q   <= err_d;
         done_q  <= done_d;
         ok_q    <= ok_d;
         len_q   <= len_d;
         count_q <= count_d;
      end
   end

   assign msg_done  = done_q;
   assign msg_ok    = ok_q;
   assign msg_len   = len_q;
   assign msg_count = count_q;
   assign err_sop   = err_q.sop;
   assign err_eop   = err_q.eop;
   assign err_len   = err_q.len;
   assign err_data  = err_q.data;

endmodule

// File: tb/tb_word_checker.sv
// Randomized scoreboard bench for word_checker against a message-level model.
module tb_word_checker;

   logic        clk;
   logic        rst_n;
   logic [7:0]  msg_word_cnt;
   logic        sink_en;
   logic        err_clear;
   logic        msg_done;
   logic        msg_ok;
   logic [7:0]  msg_len;
   logic [15:0] msg_count;
   logic        err_sop, err_eop, err_len, err_data;

   avalon_st_if #(.DATA_WIDTH(128)) msg_if ();

   word_checker #(
      .DATA_WIDTH(128), .WORD_COUNTER_SIZE(8), .MSG_COUNTER_SIZE(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .msg_in(msg_if), .msg_word_cnt(msg_word_cnt),
      .sink_en(sink_en), .err_clear(err_clear), .msg_done(msg_done), .msg_ok(msg_ok),
      .msg_len(msg_len), .msg_count(msg_count), .err_sop(err_sop), .err_eop(err_eop),
      .err_len(err_len), .err_data(err_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests_run = 0;
   int tests_failed = 0;

   task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model (message level) ----------------
   typedef struct { int len; bit ok; int count; } done_t;
   done_t exp_q[$];

   bit m_open;       // a message has been started by sop and not closed
   int m_n;          // true number of accepted beats in the open message
   int m_exp;
   bit m_bad;
   bit m_sop, m_eop, m_len, m_data;
   int m_count;

   function automatic void model_reset();
      m_open = 0; m_n = 0; m_exp = 0; m_bad = 0;
      m_sop = 0; m_eop = 0; m_len = 0; m_data = 0; m_count = 0;
   endfunction

   function automatic void model_accept(bit s, bit e, bit derr, int wc);
      done_t d;
      if (derr) m_data = 1;
      if (s) begin
         if (m_open) m_eop = 1;
         m_open = 1; m_n = 1; m_exp = wc; m_bad = derr;
      end else if (!m_open) begin
         m_sop = 1;
         return;
      end else begin
         m_n++;
         m_bad |= derr;
      end
      if (e) begin
         m_open = 0;
         d.len = (m_n > 255) ? 255 : m_n;
         if (m_n != m_exp) m_len = 1;
         d.ok = (m_n == m_exp) && !m_bad;
         m_count = (m_count + 1) % 65536;
         d.count = m_count;
         exp_q.push_back(d);
      end
   endfunction

   // ---------------- stimulus ----------------
   bit tog;

   task automatic beat(input bit v, input bit s, input bit e, input logic [127:0] d,
                       input logic [3:0] em, input bit en, input bit clr);
      msg_if.valid = v; msg_if.sop = s; msg_if.eop = e;
      msg_if.data = d; msg_if.empty = em;
      sink_en = en; err_clear = clr;
      if (clr) begin
         m_sop = 0; m_eop = 0; m_len = 0; m_data = 0; m_count = 0;
      end
      if (v && en) model_accept(s, e, (d != '0) || (em != '0), int'(msg_word_cnt));
      @(posedge clk); #1;
      msg_if.valid = 1'b0; err_clear = 1'b0;
   endtask

   // stall: 0 none, 1 random, 2 toggle sink_en every cycle
   task automatic send_beat(input bit s, input bit e, input logic [127:0] d,
                            input logic [3:0] em, input int stall);
      bit en;
      for (int tries = 0; tries < 40; tries++) begin
         if (stall == 1) en = ($urandom_range(99) >= 35) || (tries > 20);
         else if (stall == 2) begin en = tog; tog = ~tog; end
         else en = 1;
         beat(1, s, e, d, em, en, 0);
         if (en) break;
      end
   endtask

   task automatic send_msg(input int n, input int exp_len, input int derr_idx, input int stall);
      logic [127:0] d;
      msg_word_cnt = 8'(exp_len);
      for (int i = 0; i < n; i++) begin
         d = '0;
         if (i == derr_idx) d = 128'(1) << $urandom_range(127);
         send_beat(i == 0, i == n - 1, d, 4'h0, stall);
      end
   endtask

   task automatic idle(input int n, input bit clr);
      for (int i = 0; i < n; i++) beat(0, 0, 0, '0, 4'h0, 1, clr && (i == 0));
   endtask

   task automatic check_flags(input string tag);
      chk({tag, ".err_sop"},  err_sop,  m_sop);
      chk({tag, ".err_eop"},  err_eop,  m_eop);
      chk({tag, ".err_len"},  err_len,  m_len);
      chk({tag, ".err_data"}, err_data, m_data);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, ".msg_done"},  msg_done,  0);
      chk({tag, ".msg_ok"},    msg_ok,    0);
      chk({tag, ".msg_len"},   msg_len,   0);
      chk({tag, ".msg_count"}, msg_count, 0);
      check_flags(tag);
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (rst_n && msg_done) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_msg_done", 1, 0);
         end else begin
            done_t d;
            d = exp_q.pop_front();
            chk("done.msg_len",   msg_len,   d.len);
            chk("done.msg_ok",    msg_ok,    d.ok);
            chk("done.msg_count", msg_count, d.count);
         end
      end
   end

   initial begin
      rst_n = 1'b0; msg_word_cnt = '0; sink_en = 1'b0; err_clear = 1'b0;
      msg_if.valid = 1'b0; msg_if.sop = 1'b0; msg_if.eop = 1'b0;
      msg_if.data = '0; msg_if.empty = '0;
      tog = 1;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      chk("ready_follows_sink_en", msg_if.ready, sink_en);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // basic 4-beat message
      send_msg(4, 4, -1, 0);
      idle(2, 0);
      check_flags("basic");
      // short message, then clear
      send_msg(3, 4, -1, 0);
      idle(2, 0);
      check_flags("short");
      idle(1, 1);
      check_flags("after_clear");
      chk("after_clear.msg_count", msg_count, 0);
      // single-beat message, then stray beat proves FSM back in IDLE
      send_msg(1, 1, -1, 0);
      idle(1, 0);
      send_beat(0, 0, '0, 4'h0, 0);
      check_flags("single_then_stray");
      idle(1, 1);
      // abandoned message then normal restart
      msg_word_cnt = 8'd5;
      send_beat(1, 0, '0, 4'h0, 0);
      send_beat(0, 0, '0, 4'h0, 0);
      send_msg(2, 2, -1, 0);
      idle(2, 0);
      check_flags("abandon");
      idle(1, 1);
      // data error with toggling backpressure
      send_msg(4, 4, 2, 2);
      idle(2, 0);
      check_flags("toggle_data");
      // empty nonzero on a dropped beat
      beat(1, 0, 0, '0, 4'h3, 1, 0);
      check_flags("empty_dropped");
      idle(1, 1);
      // saturating length
      send_msg(300, 255, -1, 0);
      idle(2, 0);
      check_flags("saturate");
      // exp_len = 0 and clear coinciding with completion
      msg_word_cnt = 8'd0;
      send_beat(1, 0, '0, 4'h0, 0);
      msg_if.valid = 1; msg_if.sop = 0; msg_if.eop = 1; msg_if.data = '0; msg_if.empty = '0;
      beat(1, 0, 1, '0, 4'h0, 1, 1);
      idle(2, 0);
      check_flags("exp0_clear_coincide");
      chk("exp0_clear_coincide.msg_count", msg_count, 1);

      // randomized traffic
      for (int it = 0; it < 60; it++) begin
         int kind, n, ex;
         kind = $urandom_range(9);
         if (kind == 0) begin
            send_beat(0, 0, '0, 4'h0, 1);
         end else if (kind == 1) begin
            msg_word_cnt = 8'($urandom_range(8));
            n = $urandom_range(3);
            send_beat(1, 0, '0, 4'h0, 1);
            for (int k = 0; k < n; k++) send_beat(0, 0, '0, 4'h0, 1);
         end else if (kind == 2) begin
            idle(1, 1);
         end else begin
            n = $urandom_range(8, 1);
            ex = ($urandom_range(99) < 70) ? n : $urandom_range(9);
            send_msg(n, ex, ($urandom_range(99) < 15) ? $urandom_range(n - 1) : -1,
                     $urandom_range(1));
         end
         check_flags("random");
      end
      idle(3, 0);

      // reset mid-message
      msg_word_cnt = 8'd6;
      send_beat(1, 0, '0, 4'h0, 0);
      send_beat(0, 0, '0, 4'h0, 0);
      rst_n = 1'b0;
      model_reset();
      #2;
      check_reset_outputs("mid_reset");
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      send_beat(0, 0, '0, 4'h0, 0);
      check_flags("post_reset_stray");

      idle(4, 0);
      chk("pending_completions", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Global watchdog
   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
